serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//  - Serial receiver and checker for even-parity frames. It is the sequential consumer stage of the gxor gate.
//  - Samples one bit per qualified cycle: DATA_W data bits, LSB first, then one parity bit.
//  - Accumulates the XOR of the bits in a running register. Emits the assembled word plus a parity-error flag.
//  - Sits between a bit-serial source (test pattern or shift link) and word-wide logic downstream.
// PARAMETERS
//  - DATA_W   8   data bits per frame (>=1); parity bit follows the last data bit
//  - CNT_W    8   width of the error counter (used only with SPR_ERR_COUNT_EN)
// PORTS
//  - clk        in   1        single clock; all logic updates on its rising edge
//  - rst_n      in   1        synchronous active-low reset, sampled on rising edge of clk
//  - in_valid   in   1        in_bit is qualified this cycle
//  - in_bit     in   1        serial data/parity bit
//  - out_valid  out  1        one-cycle pulse: a frame completed
//  - out_data   out  DATA_W   last completed word, bit0 = first received bit
//  - out_err    out  1        1 = parity mismatch on the last completed frame
//  - busy       out  1        1 = frame partially received
//  - err_count  out  CNT_W    saturating mismatch count (only with SPR_ERR_COUNT_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge) sets: state=S_DATA, bit_cnt=0, par_acc=0, shift=0.
//    Outputs after reset: out_valid=0, out_data=0, out_err=0, busy=0, err_count=0.
//  - in_valid=0: all state holds and in_bit is ignored. Exception: out_valid always drops after 1 cycle.
//  - S_DATA, on in_valid=1:
//    - shift[bit_cnt] <= in_bit; par_acc <= par_acc ^ in_bit; busy <= 1.
//    - If bit_cnt==DATA_W-1 then next state is S_PAR, else bit_cnt <= bit_cnt+1.
//  - S_PAR, on in_valid=1:
//    - out_data <= shift; out_err <= par_acc ^ in_bit; out_valid <= 1.
//    - Clear par_acc, bit_cnt, shift; busy <= 0; next state S_DATA.
//  - Even parity: XOR of the DATA_W data bits and the parity bit must equal 0. Otherwise out_err=1.
//  - Latency: out_valid/out_data/out_err are registered. They are valid in the cycle after the cycle where the parity bit is sampled.
//  - out_data and out_err hold their values until the next frame completes. out_valid is high for exactly 1 cycle per frame.
//  - Back-to-back frames: a first data bit in the cycle after a parity bit is legal. No bubble is required and no bit is lost.
//  - DATA_W=1: after a single data bit the block goes directly to S_PAR.
//  - Reset mid-frame: the partial frame is discarded, with no out_valid pulse. The next qualified bit is data bit 0.
//  - bit_cnt width is $clog2(DATA_W) (minimum 1). It never exceeds DATA_W-1.
// CONFIGURATION
//  - Macro: SPR_ERR_COUNT_EN.
//  - Defined: err_count increments on every out_valid pulse that has out_err=1. It saturates at 2^CNT_W-1. It is cleared only by reset.
//  - Undefined: the err_count port and its register are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package serial_parity_pkg contains:
//    - state encoding S_DATA=1'b0, S_PAR=1'b1
//    - the default DATA_W/CNT_W constants
//    - the even-parity helper function used by both RTL and bench
//  - One sub-module: parity_acc. It is a 1-bit registered XOR accumulator with clk, rst_n, en, clr, d and q. Its next-value XOR is built from gxor.
//  - Top level holds the FSM, bit counter, shift register, output registers and the optional counter.
// TESTING  (DATA_W=8, CNT_W=8 unless noted; bits listed in send order)
//  1. Send 1,0,1,0,0,1,0,1 then parity 0, in_valid held high.
//     Expect: out_valid for 1 cycle in the cycle after the parity bit, out_data=8'hA5, out_err=0, busy=0.
//  2. Send 8'h01 (1,0,0,0,0,0,0,0) then parity 0.
//     Expect: out_data=8'h01, out_err=1; with the macro defined, err_count goes 0->1.
//  3. Repeat scenario 1 with in_valid low for 3 cycles between every bit.
//     Expect: identical result, one pulse only, busy=1 throughout the gaps.
//  4. Back-to-back: 8'hFF with parity 0, then immediately 8'h80 with parity 1.
//     Expect: two pulses 9 cycles apart; FF/err 0, then 80/err 0.
//  5. Send 4 data bits of any value, pull rst_n low 1 cycle, then send 8'h3C with parity 0.
//     Expect: all outputs 0 after reset, then exactly one pulse with out_data=8'h3C, out_err=0.
//  6. With the macro defined, send 260 frames that all have a parity error.
//     Expect: err_count=255 after frame 255 and still 255 after frame 260; out_err=1 on every pulse.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared definitions for the even-parity serial receiver: state encoding,
// default sizes and the XOR/parity helpers.
package serial_parity_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } spr_state_t;

  // Two-input XOR gate (gxor) shared by the accumulator and the error check.
  function automatic logic gxor(input logic a, input logic b);
    return a ^ b;
  endfunction

  // Even-parity bit for up to 32 data bits: the bit that makes the total XOR zero.
  function automatic logic even_parity_bit(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// 1-bit registered XOR accumulator: q <= q ^ d when en, cleared by clr or reset.
module parity_acc
  import serial_parity_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic acc_r;
  logic acc_nxt_s;

  // Next value: clear has priority over accumulation.
  always_comb begin
    acc_nxt_s = acc_r;
    if (clr) begin
      acc_nxt_s = 1'b0;
    end else if (en) begin
      acc_nxt_s = gxor(acc_r, d);
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
    end
  end

  assign q = acc_r;

endmodule

// File: rtl/serial_parity_rx.sv
// Even-parity serial frame receiver (DATA_W data bits LSB first, then parity).
// Optional saturating parity-error counter enabled by macro SPR_ERR_COUNT_EN.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
`ifdef SPR_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int CNT_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(DATA_W - 1);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("serial_parity_rx: DATA_W must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("serial_parity_rx: CNT_W must be >= 1");
  end

  spr_state_t        state_r;
  spr_state_t        state_nxt_s;
  logic [CNT_BW-1:0] bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_err_r;
  logic              busy_r;
  logic              par_acc_s;
  logic              acc_en_s;
  logic              frame_done_s;
  logic              frame_err_s;

  // Next-state and per-cycle strobes; nothing moves without in_valid.
  always_comb begin
    state_nxt_s  = state_r;
    acc_en_s     = 1'b0;
    frame_done_s = 1'b0;
    frame_err_s  = gxor(par_acc_s, in_bit);
    if (in_valid) begin
      case (state_r)
        S_DATA: begin
          acc_en_s = 1'b1;
          if (bit_cnt_r == LAST_CNT) begin
            state_nxt_s = S_PAR;
          end else begin
            state_nxt_s = S_DATA;
          end
        end
        S_PAR: begin
          frame_done_s = 1'b1;
          state_nxt_s  = S_DATA;
        end
        default: begin
          state_nxt_s = S_DATA;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_DATA;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  parity_acc u_parity_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (acc_en_s),
    .clr  (frame_done_s),
    .d    (in_bit),
    .q    (par_acc_s)
  );

  // Bit counter, shift register and registered frame outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_r   <= {CNT_BW{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (acc_en_s) begin
        shift_r[bit_cnt_r] <= in_bit;
        busy_r             <= 1'b1;
        if (bit_cnt_r != LAST_CNT) begin
          bit_cnt_r <= bit_cnt_r + CNT_BW'(1);
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else if (frame_done_s) begin
        out_data_r  <= shift_r;
        out_err_r   <= frame_err_s;
        out_valid_r <= 1'b1;
        shift_r     <= {DATA_W{1'b0}};
        bit_cnt_r   <= {CNT_BW{1'b0}};
        busy_r      <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

`ifdef SPR_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_r;

  // Saturating count, updated together with the pulse it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (frame_done_s && frame_err_s && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (DATA_W=8, CNT_W=8); counter checks
// are compiled in when SPR_ERR_COUNT_EN is defined.
module tb_serial_parity_rx;
  import serial_parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;
  logic       busy;
`ifdef SPR_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  serial_parity_rx #(.DATA_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_err  (out_err),
    .busy     (busy)
`ifdef SPR_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", out_err); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef SPR_ERR_COUNT_EN
    n_vec++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
`endif
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_pulse: bit %0d got %b expected 0", i, out_valid); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: bit %0d got %b expected 1", i, busy); end
    end
    drive_bit(1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_pulse: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h expected a5", out_data); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", out_err); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    idle(1);
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL basic_hold: got %h expected a5", out_data); end
  endtask

  task automatic test_parity_error();
    logic [7:0] d;
    d = 8'h01;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL perr_pulse: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'h01) begin n_bad++; $display("FAIL perr_data: got %h expected 01", out_data); end
    n_vec++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL perr_err: got %b expected 1", out_err); end
`ifdef SPR_ERR_COUNT_EN
    n_vec++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL perr_errcnt: got %0d expected 1", err_count); end
`endif
    idle(1);
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    logic [8:0] bits;
    int pulses;
    d = 8'hA5;
    bits = {1'b0, d};
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive_bit(bits[i]);
      if (out_valid === 1'b1) pulses++;
      if (i == 8) begin
        n_vec++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL gaps_data: got %h expected a5", out_data); end
        n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL gaps_err: got %b expected 0", out_err); end
      end
      for (int g = 0; g < 3; g++) begin
        idle(1);
        if (out_valid === 1'b1) pulses++;
        n_vec++;
        if (busy !== (i < 8)) begin
          n_bad++; $display("FAIL gaps_busy: bit %0d gap %0d got %b expected %b", i, g, busy, (i < 8));
        end
      end
    end
    n_vec++; if (pulses !== 1) begin n_bad++; $display("FAIL gaps_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int t1;
    d = 8'hFF;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    t1 = cyc;
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pulse1: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'hFF) begin n_bad++; $display("FAIL b2b_data1: got %h expected ff", out_data); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err1: got %b expected 0", out_err); end
    d = 8'h80;
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 0) begin
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b expected 0", out_valid); end
      end
    end
    drive_bit(1'b1);
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_pulse2: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'h80) begin n_bad++; $display("FAIL b2b_data2: got %h expected 80", out_data); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err2: got %b expected 0", out_err); end
    n_vec++; if ((cyc - t1) !== 9) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 9", cyc - t1); end
    idle(1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    logic [8:0] bits;
    int pulses;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL mrst_data: got %h expected 00", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    d = 8'h3C;
    bits = {1'b0, d};
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive_bit(bits[i]);
      if (out_valid === 1'b1) pulses++;
    end
    n_vec++; if (out_data !== 8'h3C) begin n_bad++; $display("FAIL mrst_frame_data: got %h expected 3c", out_data); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL mrst_frame_err: got %b expected 0", out_err); end
    idle(1);
    n_vec++; if (pulses !== 1) begin n_bad++; $display("FAIL mrst_pulses: got %0d expected 1", pulses); end
  endtask

`ifdef SPR_ERR_COUNT_EN
  task automatic test_saturate();
    logic [7:0] d;
    logic       p;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d = 8'h01;
    p = ~even_parity_bit({24'h000000, d});
    for (int f = 1; f <= 260; f++) begin
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      n_vec++;
      if (out_valid !== 1'b1 || out_err !== 1'b1) begin
        n_bad++; $display("FAIL sat_frame: frame %0d got valid %b err %b expected 1 1", f, out_valid, out_err);
      end
      if (f == 255) begin
        n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d expected 255", err_count); end
      end
    end
    n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_260: got %0d expected 255", err_count); end
    idle(1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    test_reset();
    test_basic();
    test_parity_error();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
`ifdef SPR_ERR_COUNT_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
